// File: rtl/trace_dispatcher.sv
// trace_dispatcher
//
// Buffers timestamped memory requests (time, op, address) from the trace
// front end in a DEPTH-entry FIFO. Each request is released downstream on a
// valid/ready handshake once the free-running cycle counter has reached its
// timestamp. When the head is still waiting, fast_fwd lets the counter jump
// straight to the head timestamp so idle stretches of the trace cost one cycle.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake from the trace front end
//   in_time/op/address  incoming request fields
//   out_valid/out_ready request handshake to the controller queue
//   out_op/address/time head request fields (read 0 while empty)
//   fast_fwd          allow skipping idle cycles up to the head timestamp
//   clock_count       current cycle counter (saturating)
//   state             head status: 0 EMPTY, 1 WAITING, 2 READY
//   fill              occupied entries
//   order_err         sticky: a timestamp below the previous accepted one arrived
//   late_count        saturating count of READY cycles with out_ready low
module trace_dispatcher #(
    parameter int ADDRESS_WIDTH = 33,
    parameter int OP_WIDTH      = 2,
    parameter int TIME_WIDTH    = 32,
    parameter int DEPTH         = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [TIME_WIDTH-1:0]       in_time,
    input  logic [OP_WIDTH-1:0]         in_op,
    input  logic [ADDRESS_WIDTH-1:0]    in_address,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OP_WIDTH-1:0]         out_op,
    output logic [ADDRESS_WIDTH-1:0]    out_address,
    output logic [TIME_WIDTH-1:0]       out_time,
    input  logic                        fast_fwd,
    output logic [TIME_WIDTH-1:0]       clock_count,
    output logic [1:0]                  state,
    output logic [$clog2(DEPTH+1)-1:0]  fill,
    output logic                        order_err,
    output logic [15:0]                 late_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_WAITING = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    // Entry storage; no reset needed since fill gates every read.
    logic [TIME_WIDTH-1:0]    mem_time [DEPTH];
    logic [OP_WIDTH-1:0]      mem_op   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] mem_addr [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [FILL_W-1:0]     fill_reg;
    logic [FILL_W-1:0]     fill_next;
    logic [TIME_WIDTH-1:0] clock_reg;
    logic [TIME_WIDTH-1:0] clock_next;
    logic [TIME_WIDTH-1:0] last_time_reg;
    logic                  order_err_reg;
    logic [15:0]           late_reg;

    logic                  not_empty;
    logic [TIME_WIDTH-1:0] head_time;
    state_t                head_state;
    logic                  push;
    logic                  pop;

    assign not_empty = (fill_reg != '0);
    assign head_time = mem_time[rd_ptr_reg];

    // Head status is a pure decode of registered state: no fall-through, so a
    // freshly pushed entry is only seen from the following cycle.
    always_comb begin
        head_state = ST_EMPTY;
        if (not_empty) begin
            if (head_time > clock_reg) begin
                head_state = ST_WAITING;
            end else begin
                head_state = ST_READY;
            end
        end
    end

    assign in_ready  = (fill_reg != FILL_W'(DEPTH));
    assign out_valid = (head_state == ST_READY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Masking with not_empty makes the data outputs read 0 out of reset.
    assign out_time    = not_empty ? head_time              : '0;
    assign out_op      = not_empty ? mem_op[rd_ptr_reg]     : '0;
    assign out_address = not_empty ? mem_addr[rd_ptr_reg]   : '0;

    assign state       = head_state;
    assign fill        = fill_reg;
    assign clock_count = clock_reg;
    assign order_err   = order_err_reg;
    assign late_count  = late_reg;

    always_comb begin
        fill_next = fill_reg;
        case ({push, pop})
            2'b10:   fill_next = fill_reg + FILL_W'(1);
            2'b01:   fill_next = fill_reg - FILL_W'(1);
            default: fill_next = fill_reg;
        endcase
    end

    // Fast-forward only ever moves the counter forwards, because WAITING
    // implies head_time > clock_reg.
    always_comb begin
        clock_next = clock_reg;
        if ((head_state == ST_WAITING) && fast_fwd) begin
            clock_next = head_time;
        end else if (clock_reg != '1) begin
            clock_next = clock_reg + TIME_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_time[wr_ptr_reg] <= in_time;
            mem_op[wr_ptr_reg]   <= in_op;
            mem_addr[wr_ptr_reg] <= in_address;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            fill_reg      <= '0;
            clock_reg     <= '0;
            last_time_reg <= '0;
            order_err_reg <= 1'b0;
            late_reg      <= '0;
        end else begin
            fill_reg  <= fill_next;
            clock_reg <= clock_next;
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (push) begin
                wr_ptr_reg    <= wr_ptr_reg + PTR_W'(1);
                last_time_reg <= in_time;
                if (in_time < last_time_reg) begin
                    order_err_reg <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if ((head_state == ST_READY) && !out_ready && (late_reg != 16'hFFFF)) begin
                late_reg <= late_reg + 16'd1;
            end
        end
    end

endmodule
